lcd_timing_controller: RTL and testbench

Sequences the LCD/PPU datapath through the per-line modes (OAM scan, pixel transfer, H-blank, V-blank) and maintains the LY line counter. Produces the STAT mode and coincidence fields, the STAT and V-blank interrupt requests, and the CPU-side VRAM/OAM access grants. Sits between the LCDC/STAT/LYC register file and the pixel pipeline. It is the single source of video timing for the rest of the video subsystem.

---
 rtl/lcd_timing_controller_pkg.sv | 44 ++++
 rtl/lcd_timing_controller_stat_irq.sv | 53 +++++
 rtl/lcd_timing_controller.sv | 147 ++++++++++++++
 tb/tb_lcd_timing_controller.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_timing_controller_pkg.sv
// -----------------------------------------------------------------------------
// lcd_timing_controller_pkg
//
// Shared video types and timing constants. The LCD mode encoding is the
// hardware encoding of the STAT mode field. The register file writes the
// mode output of the timing controller straight into that field.
//
// Contents:
//   lcd_mode_e       HBLANK=0, VBLANK=1, OAM_SCAN=2, TRANSFER=3
//   DOTS_PER_LINE    dots per scanline
//   OAM_DOTS         length of the OAM scan phase
//   XFER_DOTS        length of the pixel transfer phase (fixed)
//   VISIBLE_LINES    visible lines; equals LCD_LINES
//   TOTAL_LINES      visible lines plus V-blank lines
//   oam_access_ok()  CPU may touch OAM in this mode
//   vram_access_ok() CPU may touch VRAM in this mode
// -----------------------------------------------------------------------------
package lcd_timing_controller_pkg;

  typedef enum logic [1:0] {
    HBLANK   = 2'd0,
    VBLANK   = 2'd1,
    OAM_SCAN = 2'd2,
    TRANSFER = 2'd3
  } lcd_mode_e;

  localparam int DOTS_PER_LINE = 456;
  localparam int OAM_DOTS      = 80;
  localparam int XFER_DOTS     = 172;
  localparam int VISIBLE_LINES = 144;
  localparam int LCD_LINES     = VISIBLE_LINES;
  localparam int TOTAL_LINES   = 154;

  // The PPU reads OAM during OAM scan and transfer. Both phases lock the CPU out.
  function automatic logic oam_access_ok(input lcd_mode_e m);
    return (m == HBLANK) || (m == VBLANK);
  endfunction

  // The PPU reads VRAM only while it transfers pixels.
  function automatic logic vram_access_ok(input lcd_mode_e m);
    return (m != TRANSFER);
  endfunction

endpackage

// File: rtl/lcd_timing_controller_stat_irq.sv
// -----------------------------------------------------------------------------
// lcd_stat_irq
//
// Combines the enabled STAT sources into the single STAT interrupt line.
// It raises a one-clk request on a 0->1 edge of that line only.
// If one source is already holding the line high, a second source that rises
// produces no new request. This is the STAT-blocking behaviour that software
// relies on.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   enable       video timing is running; the line is forced low otherwise
//   stat_ie      {coincidence, mode2, mode1, mode0} interrupt enables
//   mode         current (registered) LCD mode
//   coincidence  registered ly == lyc
//   stat_irq     one-clk request pulse
// -----------------------------------------------------------------------------
module lcd_stat_irq
  import lcd_timing_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [3:0] stat_ie,
  input  lcd_mode_e  mode,
  input  logic       coincidence,
  output logic       stat_irq
);

  logic stat_line;
  logic stat_line_q;

  always_comb begin
    stat_line = enable & ((stat_ie[3] & coincidence)
                        | (stat_ie[2] & (mode == OAM_SCAN))
                        | (stat_ie[1] & (mode == VBLANK))
                        | (stat_ie[0] & (mode == HBLANK)));
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_line_q <= 1'b0;
      stat_irq    <= 1'b0;
    end else begin
      stat_line_q <= stat_line;
      stat_irq    <= stat_line & ~stat_line_q;
    end
  end

endmodule

// File: rtl/lcd_timing_controller.sv
// -----------------------------------------------------------------------------
// lcd_timing_controller
//
// Single source of video timing. It steps the dot and line counters on every
// dot-clock enable and walks the per-line mode sequence:
//   OAM scan -> transfer -> H-blank        on visible lines
//   V-blank                                on lines VISIBLE_LINES..TOTAL_LINES-1
// It also derives the CPU access grants, the LY==LYC coincidence flag, the
// V-blank interrupt and, through lcd_stat_irq, the STAT interrupt.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   dot_en       dot-clock enable; timing advances only when high
//   lcd_enable   LCDC.LCDEnable
//   stat_ie      STAT {coincidence, mode2, mode1, mode0} interrupt enables
//   lyc          LY compare value
//   mode         current mode (lcd_mode_e)
//   ly           current line, 0..TOTAL_LINES-1
//   coincidence  registered ly == lyc, refreshed every clk
//   stat_irq     one-clk STAT request
//   vblank_irq   one-clk request on entry to V-blank
//   vram_cpu_ok  CPU may access VRAM
//   oam_cpu_ok   CPU may access OAM
//   line_start   one-clk pulse at dot 0 of every line
//   dot          dot within the line, 0..DOTS_PER_LINE-1
// -----------------------------------------------------------------------------
module lcd_timing_controller
  import lcd_timing_controller_pkg::*;
#(
  parameter int DOTS_PER_LINE = lcd_timing_controller_pkg::DOTS_PER_LINE,
  parameter int OAM_DOTS      = lcd_timing_controller_pkg::OAM_DOTS,
  parameter int XFER_DOTS     = lcd_timing_controller_pkg::XFER_DOTS,
  parameter int VISIBLE_LINES = lcd_timing_controller_pkg::VISIBLE_LINES,
  parameter int TOTAL_LINES   = lcd_timing_controller_pkg::TOTAL_LINES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dot_en,
  input  logic       lcd_enable,
  input  logic [3:0] stat_ie,
  input  logic [7:0] lyc,
  output lcd_mode_e  mode,
  output logic [7:0] ly,
  output logic       coincidence,
  output logic       stat_irq,
  output logic       vblank_irq,
  output logic       vram_cpu_ok,
  output logic       oam_cpu_ok,
  output logic       line_start,
  output logic [8:0] dot
);

  localparam logic [8:0] LAST_DOT     = 9'(DOTS_PER_LINE - 1);
  localparam logic [8:0] XFER_START   = 9'(OAM_DOTS);
  localparam logic [8:0] HBLANK_START = 9'(OAM_DOTS + XFER_DOTS);
  localparam logic [7:0] LAST_LINE    = 8'(TOTAL_LINES - 1);
  localparam logic [7:0] VBLANK_LINE  = 8'(VISIBLE_LINES);

  // running is clear after reset and while the LCD is off. The first dot_en
  // after enabling then lands on line 0, dot 0 instead of dot 1. Otherwise the
  // first line would be one dot short.
  logic       running;
  logic [8:0] next_dot;
  logic [7:0] next_ly;
  lcd_mode_e  next_mode;

  // Counter values that the next dot_en will load.
  // NOTE: every always_comb output gets a default first. A path that skips an
  // assignment would otherwise infer a latch.
  always_comb begin
    next_dot = dot + 9'd1;
    next_ly  = ly;
    if (!running) begin
      next_dot = '0;
      next_ly  = '0;
    end else if (dot == LAST_DOT) begin
      next_dot = '0;
      next_ly  = (ly == LAST_LINE) ? '0 : ly + 8'd1;
    end
  end

  // Mode transition function. Only the legal edges of the line and frame
  // sequence exist. Any other combination holds the current mode.
  always_comb begin
    next_mode = mode;
    unique case (mode)
      OAM_SCAN: if (next_dot == XFER_START)   next_mode = TRANSFER;
      TRANSFER: if (next_dot == HBLANK_START) next_mode = HBLANK;
      HBLANK: begin
        if (next_dot == '0)
          next_mode = (next_ly < VBLANK_LINE) ? OAM_SCAN : VBLANK;
      end
      VBLANK: if (next_dot == '0 && next_ly == '0) next_mode = OAM_SCAN;
      default: next_mode = mode;
    endcase
  end

  // Mode FSM with its counters and registered outputs. Turning the LCD off
  // takes effect on the next clk, whether or not dot_en is high.
  always_ff @(posedge clk) begin
    if (rst || !lcd_enable) begin
      running     <= 1'b0;
      dot         <= '0;
      ly          <= '0;
      mode        <= HBLANK;
      line_start  <= 1'b0;
      vblank_irq  <= 1'b0;
      vram_cpu_ok <= 1'b1;
      oam_cpu_ok  <= 1'b1;
    end else begin
      // Pulses are single-clk even if dot_en stays high. A stall must not
      // stretch them.
      line_start <= 1'b0;
      vblank_irq <= 1'b0;
      if (dot_en) begin
        running     <= 1'b1;
        dot         <= next_dot;
        ly          <= next_ly;
        mode        <= next_mode;
        line_start  <= (next_dot == '0);
        vblank_irq  <= (next_mode == VBLANK) && (mode != VBLANK);
        vram_cpu_ok <= vram_access_ok(next_mode);
        oam_cpu_ok  <= oam_access_ok(next_mode);
      end
    end
  end

  // Compared every clk so that an LYC write shows up one clk later even with
  // the dot clock stalled. The compare uses the registered ly. The match on
  // line 153 therefore lasts the whole line.
  always_ff @(posedge clk) begin
    if (rst) coincidence <= 1'b0;
    else     coincidence <= (ly == lyc);
  end

  lcd_stat_irq u_stat_irq (
    .clk         (clk),
    .rst         (rst),
    .enable      (running),
    .stat_ie     (stat_ie),
    .mode        (mode),
    .coincidence (coincidence),
    .stat_irq    (stat_irq)
  );

endmodule

// File: tb/tb_lcd_timing_controller.sv
// -----------------------------------------------------------------------------
// tb_lcd_timing_controller
//
// Directed bench for lcd_timing_controller. Each tick() runs a small
// cycle-level reference model on the driven inputs and pushes the expected
// outputs into a scoreboard queue. After the clock edge it pops that entry and
// compares it with the DUT outputs. Directed checks on pulse counts, grant
// windows and frame landmarks follow each scenario.
// -----------------------------------------------------------------------------
module tb_lcd_timing_controller;
  import lcd_timing_controller_pkg::*;

  localparam int FRAME = DOTS_PER_LINE * TOTAL_LINES;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, dot_en, lcd_enable;
  logic [3:0] stat_ie;
  logic [7:0] lyc;
  lcd_mode_e  mode;
  logic [7:0] ly;
  logic [8:0] dot;
  logic       coincidence, stat_irq, vblank_irq, vram_cpu_ok, oam_cpu_ok, line_start;

  lcd_timing_controller dut (
    .clk         (clk),
    .rst         (rst),
    .dot_en      (dot_en),
    .lcd_enable  (lcd_enable),
    .stat_ie     (stat_ie),
    .lyc         (lyc),
    .mode        (mode),
    .ly          (ly),
    .coincidence (coincidence),
    .stat_irq    (stat_irq),
    .vblank_irq  (vblank_irq),
    .vram_cpu_ok (vram_cpu_ok),
    .oam_cpu_ok  (oam_cpu_ok),
    .line_start  (line_start),
    .dot         (dot)
  );

  typedef struct packed {
    logic [1:0] mode;
    logic [7:0] ly;
    logic [8:0] dot;
    logic       coin;
    logic       stat_irq;
    logic       vblank_irq;
    logic       vram_ok;
    logic       oam_ok;
    logic       line_start;
  } obs_t;

  int   n_checks = 0;
  int   n_pass   = 0;
  obs_t sb[$];

  // Reference model state
  obs_t m;
  bit   m_run;
  int   m_pos;
  bit   m_line_prev;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.mode       = mode;
    o.ly         = ly;
    o.dot        = dot;
    o.coin       = coincidence;
    o.stat_irq   = stat_irq;
    o.vblank_irq = vblank_irq;
    o.vram_ok    = vram_cpu_ok;
    o.oam_ok     = oam_cpu_ok;
    o.line_start = line_start;
    return o;
  endfunction

  // The model works on a flat frame position. Line, dot and mode are derived
  // from that position by division and range checks.
  task automatic model_step();
    bit line;
    int l, d;
    if (rst) begin
      m = '0;
      m.vram_ok = 1'b1;
      m.oam_ok  = 1'b1;
      m_run = 0;
      m_pos = 0;
      m_line_prev = 0;
    end else begin
      line = m_run && ((stat_ie[3] && m.coin) || (stat_ie[2] && m.mode == 2'd2) ||
                       (stat_ie[1] && m.mode == 2'd1) || (stat_ie[0] && m.mode == 2'd0));
      m.stat_irq  = line && !m_line_prev;
      m_line_prev = line;
      m.coin       = (m.ly == lyc);
      m.line_start = 1'b0;
      m.vblank_irq = 1'b0;
      if (!lcd_enable) begin
        m_run = 0;
        m_pos = 0;
        m.mode = 2'd0; m.ly = '0; m.dot = '0;
        m.vram_ok = 1'b1; m.oam_ok = 1'b1;
      end else if (dot_en) begin
        if (m_run) m_pos = (m_pos + 1) % FRAME;
        else begin m_run = 1; m_pos = 0; end
        l = m_pos / DOTS_PER_LINE;
        d = m_pos % DOTS_PER_LINE;
        m.ly  = 8'(l);
        m.dot = 9'(d);
        if (l >= VISIBLE_LINES)          m.mode = 2'd1;
        else if (d < OAM_DOTS)           m.mode = 2'd2;
        else if (d < OAM_DOTS+XFER_DOTS) m.mode = 2'd3;
        else                             m.mode = 2'd0;
        m.line_start = (d == 0);
        m.vblank_irq = (l == VISIBLE_LINES) && (d == 0);
        m.oam_ok     = (m.mode == 2'd0) || (m.mode == 2'd1);
        m.vram_ok    = (m.mode != 2'd3);
      end
    end
  endtask

  // One clk: push the expectation, let the edge pass, pop and compare.
  task automatic tick();
    obs_t e;
    model_step();
    sb.push_back(m);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check($sformatf("cycle ly%0d dot%0d", e.ly, e.dot), 32'(sample()), 32'(e));
  endtask

  task automatic run_until(input logic [7:0] tl, input logic [8:0] td, input int budget);
    int n = 0;
    while (!(ly == tl && dot == td) && n < budget) begin
      tick();
      n++;
    end
    check($sformatf("reach ly%0d dot%0d", tl, td), 32'(ly == tl && dot == td), 32'd1);
  endtask

  task automatic watch(input int n, output int irqs, output int starts);
    irqs = 0;
    starts = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      irqs   += int'(stat_irq);
      starts += int'(line_start);
    end
  endtask

  initial begin
    obs_t rv;
    int first_vb, first_wrap, stat_pulses, vb_pulses;
    int oam_blk, vram_blk, bad_grant, vb_grant_bad, irqs, starts;

    rv = '0;
    rv.vram_ok = 1'b1;
    rv.oam_ok  = 1'b1;

    // Reset with the LCD enabled and the dot clock free-running
    rst = 1'b1; lcd_enable = 1'b1; dot_en = 1'b1; lyc = 8'd5; stat_ie = 4'b1000;
    tick();
    tick();
    check("reset values", 32'(sample()), 32'(rv));
    rst = 1'b0;

    // Full frame at dot_en=1 with the LYC=5 coincidence interrupt enabled
    first_vb = -1; first_wrap = -1; stat_pulses = 0; vb_pulses = 0;
    oam_blk = 0; vram_blk = 0; bad_grant = 0; vb_grant_bad = 0;
    for (int i = 0; i <= FRAME; i++) begin
      if (i == 5*DOTS_PER_LINE + 200) lyc = 8'd5;   // same LYC written again mid-line
      tick();
      if (ly == 8'd144 && mode == VBLANK && first_vb < 0) first_vb = i;
      if (i > 0 && ly == 8'd0 && dot == 9'd0 && first_wrap < 0) first_wrap = i;
      stat_pulses += int'(stat_irq);
      vb_pulses   += int'(vblank_irq);
      if (ly == 8'd10) begin
        if (!oam_cpu_ok) begin
          oam_blk++;
          if (dot > 9'd251) bad_grant++;
        end
        if (!vram_cpu_ok) begin
          vram_blk++;
          if (dot < 9'd80 || dot > 9'd251) bad_grant++;
        end
      end
      if (mode == VBLANK && !(oam_cpu_ok && vram_cpu_ok)) vb_grant_bad++;
    end
    check("vblank entry cycle", 32'(first_vb), 32'd65664);
    check("frame wrap cycle", 32'(first_wrap), 32'd70224);
    check("vblank_irq pulses per frame", 32'(vb_pulses), 32'd1);
    check("lyc=5 stat pulses", 32'(stat_pulses), 32'd1);
    check("line10 oam blocked dots", 32'(oam_blk), 32'd252);
    check("line10 vram blocked dots", 32'(vram_blk), 32'd172);
    check("line10 grant window", 32'(bad_grant), 32'd0);
    check("vblank grants", 32'(vb_grant_bad), 32'd0);

    // Mode-0 source alone: entering H-blank on line 2 raises one request
    lyc = 8'd2; stat_ie = 4'b0001;
    run_until(8'd2, 9'd240, 2000);
    watch(61, irqs, starts);
    check("mode0 entry pulse (ie=0001)", 32'(irqs), 32'd1);

    // Coincidence + mode-0: the match raises the line, and H-blank entry is blocked
    lyc = 8'd4; stat_ie = 4'b1001;
    run_until(8'd4, 9'd0, 1000);
    watch(240, irqs, starts);
    check("coincidence pulse line 4", 32'(irqs), 32'd1);
    watch(61, irqs, starts);
    check("blocked mode0 entry (ie=1001)", 32'(irqs), 32'd0);

    // LCD off mid-line: counters and mode cleared on the next clk
    stat_ie = 4'b0000;
    run_until(8'd8, 9'd150, 2000);
    lcd_enable = 1'b0;
    tick();
    check("lcd off state", 32'({mode, ly, dot, vram_cpu_ok, oam_cpu_ok}),
          32'({HBLANK, 8'd0, 9'd0, 1'b1, 1'b1}));
    stat_ie = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      dot_en = k[0];
      tick();
      irqs += int'(stat_irq);
    end
    check("no irq while lcd off", 32'(irqs), 32'd0);

    // Re-enable: wait for dot_en, then restart at line 0 dot 0 in OAM scan
    stat_ie = 4'b0000; dot_en = 1'b0; lcd_enable = 1'b1;
    tick();
    check("enabled, dot clock stalled", 32'({mode, dot}), 32'({HBLANK, 9'd0}));
    dot_en = 1'b1;
    tick();
    check("restart position", 32'({mode, ly, dot, line_start}),
          32'({OAM_SCAN, 8'd0, 9'd0, 1'b1}));

    // Quarter-rate dot clock over two lines: line_start stays one clk wide
    starts = 0;
    for (int k = 0; k < 2*DOTS_PER_LINE*4; k++) begin
      dot_en = ((k % 4) == 3);
      tick();
      starts += int'(line_start);
    end
    check("quarter-rate line_start clks", 32'(starts), 32'd2);
    check("quarter-rate end position", 32'({ly, dot}), 32'({8'd2, 9'd0}));

    // Reset mid-frame overrides lcd_enable and dot_en
    dot_en = 1'b1; lyc = 8'd9; stat_ie = 4'b1000; rst = 1'b1;
    tick();
    check("mid-frame reset values", 32'(sample()), 32'(rv));
    rst = 1'b0;
    tick();

    // Stalled dot clock: an LYC write still updates coincidence and STAT
    dot_en = 1'b0;
    tick();
    tick();
    lyc = 8'd0;
    watch(4, irqs, starts);
    check("stalled lyc match irq", 32'(irqs), 32'd1);
    check("stalled coincidence", 32'({coincidence, dot}), 32'({1'b1, 9'd0}));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
